// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - operand sequencer feeding a MAC block from two show-ahead FIFOs
// Clears the MAC, issues VEC_LEN paired pops, then holds the captured dot product on valid/ready.
module mac_operand_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  output logic                      busy_o,
  input  logic                      a_empty_i,
  input  logic [DATA_WIDTH-1:0]     a_data_i,
  output logic                      a_rden_o,
  input  logic                      b_empty_i,
  input  logic [DATA_WIDTH-1:0]     b_data_i,
  output logic                      b_rden_o,
  output logic                      mac_en_o,
  output logic                      mac_clr_o,
  output logic [DATA_WIDTH-1:0]     mac_ain_o,
  output logic [DATA_WIDTH-1:0]     mac_bin_o,
  input  logic [3*DATA_WIDTH-1:0]   mac_cout_i,
  output logic [3*DATA_WIDTH-1:0]   result_o,
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic                      done_o
);
  localparam int CW = $clog2(VEC_LEN + 1);
  localparam int RW = 3 * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] result_q, result_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          issue;

  // Both FIFOs must have a word so the pair is always popped together.
  assign issue = (state_q == S_RUN) && !a_empty_i && !b_empty_i;

  assign busy_o         = (state_q != S_IDLE);
  assign mac_clr_o      = (state_q == S_CLEAR);
  assign mac_en_o       = issue;
  assign a_rden_o       = issue;
  assign b_rden_o       = issue;
  assign mac_ain_o      = issue ? a_data_i : '0;
  assign mac_bin_o      = issue ? b_data_i : '0;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign done_o         = done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (issue) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      // The MAC output reflects the last product one cycle after its issue.
      S_DRAIN: begin
        result_d = mac_cout_i;
        valid_d  = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (result_ready_i) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end
endmodule
